seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the FPGA board top level. It scans DIGITS common-anode digits from a hex word supplied over a valid/ready load port. New values are double-buffered and applied only at frame boundaries, so no tearing occurs. It adds per-digit decimal points, leading-zero suppression and optional PWM dimming.

## Interface
- DIGITS, 4: number of digits scanned (1..8).
- REFRESH_DIV, 10000: clock cycles per digit slot (≥4).
- DIM_BITS, 4: brightness resolution in bits.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  load request.
- in_ready  out  1  pending buffer free; a transfer occurs when in_valid && in_ready.
- in_data  in  4*DIGITS  hex nibbles, where nibble d drives digit d (digit 0 = rightmost).
- in_dp  in  DIGITS  decimal point enables, sampled together with in_data.
- blank_lz  in  1  leading-zero suppression enable, live (sampled each cycle).
- brightness  in  DIM_BITS  duty setting, live.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  digit anodes, active-low; at most one bit is low at any time.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation
- Registers:
  - pre: prescaler, 0..REFRESH_DIV-1.
  - idx: digit index, 0..DIGITS-1.
  - act_data/act_dp: displayed value.
  - pend_data/pend_dp/pend_full: pending buffer.
  - pwm: DIM_BITS free-running counter.
- Scan behaviour:
  - pre increments every cycle.
  - At pre==REFRESH_DIV-1, pre returns to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0; this wrap is the frame boundary.
- Load behaviour:
  - in_ready = !pend_full.
  - On a transfer, pend_* captures in_data/in_dp and pend_full is set.
  - At a frame boundary with pend_full=1, act_* takes pend_* and pend_full clears.
- Simultaneous events:
  - A transfer in the same cycle as a frame boundary is written into pend and shown at the next boundary, not the current one.
  - In that same cycle, a previously pending value moves to act and pend is refilled with the new value.
- Decode: standard hex font 0-F, active-low, with segment a = bit 0.
- Leading-zero suppression, when blank_lz=1:
  - Digit d is blanked (seg=7'h7F) if act nibbles DIGITS-1..d are all zero and d≠0.
  - Digit 0 is never suppressed.
  - The dp of a suppressed digit is still shown if its act_dp bit is set.
- Anti-ghosting: an is all ones during the pre==0 cycle of every slot.
- Anode enable: an[idx]=0 when pre≠0 and dim_on=1.
  - Without dimming, dim_on is always 1.
  - With dimming, see Configuration.

## Timing
- Reset values:
  - seg=7'h7F, dp=1, an=all ones, in_ready=1, frame_done=0.
  - pre=0, idx=0, pwm=0, act_*=0, pend_full=0.
- seg, dp, an and frame_done are registered: they reflect pre/idx/act state from the previous cycle.
- Slot length is exactly REFRESH_DIV cycles. Frame length is DIGITS×REFRESH_DIV cycles.
- frame_done is high for one cycle, in the cycle after idx wraps to 0. It is aligned with the first output cycle of digit 0.
- Load latency: a value accepted at cycle t appears on the outputs at the first frame boundary after t, plus one cycle.
- Reset asserted mid-operation:
  - All state returns to reset values on the next edge.
  - The pending value is discarded.
  - in_ready goes to 1.
- blank_lz and brightness changes take effect one cycle after they are sampled.

## Configuration
- SEG7_DIMMING_EN defined:
  - pwm increments every cycle and wraps at 2^DIM_BITS-1.
  - dim_on = (brightness == all ones) || (pwm < brightness).
  - brightness=0 keeps all anodes high.
- SEG7_DIMMING_EN undefined:
  - pwm is not built.
  - The brightness port is present but ignored, and dim_on=1.

## Test plan
Bench configuration: DIGITS=4, REFRESH_DIV=8, DIM_BITS=4.
- Reset, then idle 40 cycles with in_data=0 -> an sequence 1110,1101,1011,0111 with 7 low cycles per slot and all-ones on each pre==0 cycle; seg=7'h40 ('0'); frame_done pulses every 32 cycles.
- Load 16'h12AF mid-frame -> in_ready drops the next cycle; seg stays '0' until the boundary; then digits show F,A,2,1 (7'h0E,7'h08,7'h24,7'h79); in_ready returns to 1.
- Back-to-back: load 16'h1111, attempt 16'h2222 while in_ready=0 -> 16'h2222 is not accepted; at the boundary 1111 is shown; 2222 is accepted afterwards and shown one frame later.
- blank_lz=1, in_data=16'h0050, in_dp=4'b1000 -> digits 3 and 2 blank; digit 3 shows dp=0; digit 1 shows '5'; digit 0 shows '0'.
- SEG7_DIMMING_EN defined, brightness=4 -> an low on 4 of every 16 cycles within active slot cycles; brightness=0 -> an all ones; brightness=15 -> same as undimmed.
- Assert reset for one cycle mid-slot while pend_full=1 -> next cycle seg=7'h7F, an=1111, in_ready=1; scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Load port of the seven-segment scan driver: a valid/ready transfer of one
// complete display word (hex nibbles plus decimal point enables).
//
// Signals:
//   in_valid  producer -> driver   load request
//   in_ready  driver -> producer   pending buffer free
//   in_data   producer -> driver   4*DIGITS hex nibbles, nibble d = digit d
//   in_dp     producer -> driver   DIGITS decimal point enables
// Modports: master (producer side), slave (driver side).
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_data;
   logic [DIGITS-1:0]     in_dp;

   modport master (
      output in_valid,
      output in_data,
      output in_dp,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_dp,
      output in_ready
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Multiplexed common-anode seven-segment driver. Scans DIGITS digits, one slot
// of REFRESH_DIV clocks each. A new display word is held in a pending buffer
// and promoted to the displayed word only at the frame boundary (wrap from the
// last digit to digit 0), so a frame never mixes two words.
//
// Optional feature macro: SEG7_DIMMING_EN
//   defined   -> a free-running PWM counter gates the anodes by brightness
//   undefined -> no PWM counter, brightness is ignored, full duty
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   load        seg7_scan_driver_if.slave load port (valid/ready/data/dp)
//   blank_lz    leading-zero suppression enable (live)
//   brightness  PWM duty setting (live)
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   dp          decimal point, active-low, registered
//   an          digit anodes, active-low, at most one low, registered
//   frame_done  one-cycle pulse aligned with the first output cycle of digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 10000,
   parameter int DIM_BITS    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   seg7_scan_driver_if.slave     load,
   input  logic                  blank_lz,
   input  logic [DIM_BITS-1:0]   brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // Hex font, active-low, segment a in bit 0.
   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'h40;
         4'h1:    pat = 7'h79;
         4'h2:    pat = 7'h24;
         4'h3:    pat = 7'h30;
         4'h4:    pat = 7'h19;
         4'h5:    pat = 7'h12;
         4'h6:    pat = 7'h02;
         4'h7:    pat = 7'h78;
         4'h8:    pat = 7'h00;
         4'h9:    pat = 7'h10;
         4'hA:    pat = 7'h08;
         4'hB:    pat = 7'h03;
         4'hC:    pat = 7'h46;
         4'hD:    pat = 7'h21;
         4'hE:    pat = 7'h06;
         4'hF:    pat = 7'h0E;
         default: pat = 7'h7F;
      endcase
      return pat;
   endfunction

   // Bit d set when nibbles DIGITS-1..d are all zero and d is not digit 0.
   function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] word);
      logic              run;
      logic [DIGITS-1:0] mask;
      run  = 1'b1;
      mask = {DIGITS{1'b0}};
      for (int d = DIGITS - 1; d >= 0; d--) begin
         run     = run & (word[4*d +: 4] == 4'h0);
         mask[d] = run & (d != 0);
      end
      return mask;
   endfunction

   logic [PRE_W-1:0]    pre_r;
   logic [IDX_W-1:0]    idx_r;
   logic [4*DIGITS-1:0] act_data_r;
   logic [DIGITS-1:0]   act_dp_r;
   logic [4*DIGITS-1:0] pend_data_r;
   logic [DIGITS-1:0]   pend_dp_r;
   logic                pend_full_r;
   logic                wrap_r;
   logic [6:0]          seg_r;
   logic                dp_r;
   logic [DIGITS-1:0]   an_r;
   logic                frame_done_r;

   logic                slot_end_s;
   logic                boundary_s;
   logic                xfer_s;
   logic                dim_on_s;
   logic [DIGITS-1:0]   lz_mask_s;
   logic [3:0]          cur_nib_s;
   logic                cur_dp_s;
   logic                cur_lz_s;
   logic [DIGITS-1:0]   an_sel_s;

   assign slot_end_s    = (pre_r == PRE_LAST);
   assign boundary_s    = slot_end_s && (idx_r == IDX_LAST);
   assign xfer_s        = load.in_valid && !pend_full_r;
   assign load.in_ready = !pend_full_r;
   assign lz_mask_s     = lead_zero_mask(act_data_r);

`ifdef SEG7_DIMMING_EN
   logic [DIM_BITS-1:0] pwm_r;

   // Free-running PWM counter, wraps naturally at all ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_r <= {DIM_BITS{1'b0}};
      end else begin
         pwm_r <= pwm_r + 1'b1;
      end
   end

   // Full scale bypasses the compare so brightness=max is exactly undimmed.
   assign dim_on_s = (brightness == {DIM_BITS{1'b1}}) || (pwm_r < brightness);
`else
   logic unused_brightness_s;
   assign unused_brightness_s = ^brightness;
   assign dim_on_s            = 1'b1;
`endif

   // Select the nibble, dp and suppression flag of the digit being scanned.
   always_comb begin
      cur_nib_s = 4'h0;
      cur_dp_s  = 1'b0;
      cur_lz_s  = 1'b0;
      an_sel_s  = {DIGITS{1'b1}};
      for (int d = 0; d < DIGITS; d++) begin
         if (idx_r == IDX_W'(d)) begin
            cur_nib_s   = act_data_r[4*d +: 4];
            cur_dp_s    = act_dp_r[d];
            cur_lz_s    = lz_mask_s[d];
            an_sel_s[d] = 1'b0;
         end else begin
            an_sel_s[d] = 1'b1;
         end
      end
   end

   // Scan counters, double-buffered load path and registered display outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_r        <= {PRE_W{1'b0}};
         idx_r        <= {IDX_W{1'b0}};
         act_data_r   <= {(4*DIGITS){1'b0}};
         act_dp_r     <= {DIGITS{1'b0}};
         pend_data_r  <= {(4*DIGITS){1'b0}};
         pend_dp_r    <= {DIGITS{1'b0}};
         pend_full_r  <= 1'b0;
         wrap_r       <= 1'b0;
         seg_r        <= 7'h7F;
         dp_r         <= 1'b1;
         an_r         <= {DIGITS{1'b1}};
         frame_done_r <= 1'b0;
      end else begin
         if (slot_end_s) begin
            pre_r <= {PRE_W{1'b0}};
            idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + 1'b1;
         end else begin
            pre_r <= pre_r + 1'b1;
         end

         // Promotion uses the old pending word, so a same-cycle transfer
         // lands in pend and waits for the following boundary.
         if (boundary_s && pend_full_r) begin
            act_data_r <= pend_data_r;
            act_dp_r   <= pend_dp_r;
         end

         if (xfer_s) begin
            pend_data_r <= load.in_data;
            pend_dp_r   <= load.in_dp;
            pend_full_r <= 1'b1;
         end else if (boundary_s) begin
            pend_full_r <= 1'b0;
         end

         // wrap_r marks the first state cycle of digit 0; the outputs of that
         // state appear one cycle later, which is when frame_done pulses.
         wrap_r       <= boundary_s;
         frame_done_r <= wrap_r;

         seg_r <= (blank_lz && cur_lz_s) ? 7'h7F : hex_font(cur_nib_s);
         dp_r  <= ~cur_dp_s;
         // pre==0 keeps every anode off for one cycle to stop ghosting.
         an_r  <= ((pre_r != {PRE_W{1'b0}}) && dim_on_s) ? an_sel_s : {DIGITS{1'b1}};
      end
   end

   assign seg        = seg_r;
   assign dp         = dp_r;
   assign an         = an_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=8,
// DIM_BITS=4). A reference model derives the scan position from a cycle count
// since reset, keeps the displayed/pending words, and predicts every output
// each cycle. Honours SEG7_DIMMING_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;
   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 8;
   localparam int DIM_BITS    = 4;
   localparam int FRAME       = DIGITS * REFRESH_DIV;

   localparam logic [6:0] FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic                clk = 1'b0;
   logic                reset;
   logic                blank_lz;
   logic [DIM_BITS-1:0] brightness;
   logic [6:0]          seg;
   logic                dp;
   logic [DIGITS-1:0]   an;
   logic                frame_done;

   seg7_scan_driver_if #(.DIGITS(DIGITS)) ld ();

   seg7_scan_driver #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .DIM_BITS    (DIM_BITS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (ld),
      .blank_lz   (blank_lz),
      .brightness (brightness),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Reference model state
   int unsigned         n_m;          // cycles since reset release
   logic [15:0]         act_m;
   logic [DIGITS-1:0]   act_dp_m;
   logic [15:0]         pend_m;
   logic [DIGITS-1:0]   pend_dp_m;
   bit                  pend_full_m;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (model cycle %0d, t=%0t)", tag, got, exp, n_m, $time);
      end
   endtask

   // One clock: predict outputs from the pre-edge state, advance, compare.
   task automatic step();
      logic [6:0]        e_seg;
      logic              e_dp;
      logic [DIGITS-1:0] e_an;
      logic              e_fd;
      logic [15:0]       sh;
      int                pre;
      int                idx;
      bit                dim_on;
      bit                xfer;
      bit                boundary;
      if (reset) begin
         e_seg = 7'h7F;
         e_dp  = 1'b1;
         e_an  = {DIGITS{1'b1}};
         e_fd  = 1'b0;
      end else begin
         pre = int'(n_m % REFRESH_DIV);
         idx = int'((n_m / REFRESH_DIV) % DIGITS);
         sh  = act_m >> (4 * idx);
         if (blank_lz && idx != 0 && sh == 16'h0) e_seg = 7'h7F;
         else e_seg = FONT[sh[3:0]];
         e_dp = ~act_dp_m[idx];
`ifdef SEG7_DIMMING_EN
         dim_on = (brightness == 4'hF) || ((n_m % 16) < brightness);
`else
         dim_on = 1'b1;
`endif
         e_an = {DIGITS{1'b1}};
         if (pre != 0 && dim_on) e_an[idx] = 1'b0;
         e_fd = (n_m != 0) && (n_m % FRAME == 0);
      end
      xfer     = !reset && ld.in_valid && !pend_full_m;
      boundary = (n_m % FRAME) == FRAME - 1;
      @(posedge clk);
      #1;
      if (reset) begin
         n_m         = 0;
         act_m       = 16'h0;
         act_dp_m    = '0;
         pend_full_m = 1'b0;
      end else begin
         if (boundary && pend_full_m) begin
            act_m       = pend_m;
            act_dp_m    = pend_dp_m;
            pend_full_m = 1'b0;
         end
         if (xfer) begin
            pend_m      = ld.in_data;
            pend_dp_m   = ld.in_dp;
            pend_full_m = 1'b1;
         end
         n_m++;
      end
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("an", 32'(an), 32'(e_an));
      check("frame_done", 32'(frame_done), 32'(e_fd));
      check("in_ready", 32'(ld.in_ready), 32'(!pend_full_m));
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   // Hold a request until the model says it was accepted (bounded).
   task automatic load_word(input logic [15:0] d, input logic [DIGITS-1:0] p);
      bit accepted;
      accepted     = 1'b0;
      ld.in_data   = d;
      ld.in_dp     = p;
      ld.in_valid  = 1'b1;
      for (int i = 0; i < 4 * FRAME && !accepted; i++) begin
         accepted = !pend_full_m;
         step();
      end
      ld.in_valid = 1'b0;
      check("load_accept", 32'(accepted), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_m         = 0;
      act_m       = 16'h0;
      act_dp_m    = '0;
      pend_m      = 16'h0;
      pend_dp_m   = '0;
      pend_full_m = 1'b0;
      reset       = 1'b1;
      blank_lz    = 1'b0;
      brightness  = 4'hF;
      ld.in_valid = 1'b0;
      ld.in_data  = 16'h0;
      ld.in_dp    = '0;
      run(2);
      reset = 1'b0;

      // Idle scan of zeros
      run(40);

      // Mid-frame load, observed across the boundary
      load_word(16'h12AF, 4'b0000);
      check("ready_drop", 32'(ld.in_ready), 32'd0);
      run(2 * FRAME);

      // Back-to-back: second word must wait for the pending slot
      load_word(16'h1111, 4'b0001);
      load_word(16'h2222, 4'b0010);
      run(2 * FRAME + 4);

      // Leading-zero suppression with dp on a blanked digit
      blank_lz = 1'b1;
      load_word(16'h0050, 4'b1000);
      run(2 * FRAME);

      // Brightness settings
      brightness = 4'd4;
      run(2 * FRAME);
      brightness = 4'd0;
      run(FRAME);
      brightness = 4'd15;
      run(FRAME);

      // Randomised traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            ld.in_data  = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            ld.in_dp    = 4'($urandom_range(0, 15));
            ld.in_valid = 1'b1;
         end else begin
            ld.in_valid = 1'b0;
         end
         if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 59) == 0) brightness = 4'($urandom_range(0, 15));
         step();
      end
      ld.in_valid = 1'b0;
      brightness  = 4'hF;

      // Reset mid-slot with a word pending
      for (int i = 0; i < REFRESH_DIV && (n_m % REFRESH_DIV) != 2; i++) step();
      load_word(16'hBEEF, 4'b0101);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_ready", 32'(ld.in_ready), 32'd1);
      run(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
